// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds the FSM state encoding and the multiply/divide latency defaults.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 32;
  localparam int MDU_CNT_W       = 6;

  // The cycle of acceptance is itself a stall cycle, so the counter starts one short.
  function automatic logic [MDU_CNT_W-1:0] mdu_load_val(input int cycles);
    return MDU_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side hazard inputs and stage-register controls, grouped as one bundle.
// master = pipeline datapath, slave = hazard controller.
interface pipeline_hazard_controller_if;
  logic       id_ex_memread;
  logic [4:0] id_ex_rt_addr;
  logic [4:0] if_id_rs_addr;
  logic [4:0] if_id_rt_addr;
  logic       branch_taken;
  logic       mdu_start;
  logic       mdu_is_div;
  logic       mem_access;
  logic       dmem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_write;
  logic        id_ex_bubble;
  logic        ex_mem_write;
  logic        ex_mem_bubble;
  logic        mem_wb_bubble;
  logic        mdu_busy;
  logic        mdu_done;
  logic [15:0] stall_count;

  modport master (
    output id_ex_memread, id_ex_rt_addr, if_id_rs_addr, if_id_rt_addr,
           branch_taken, mdu_start, mdu_is_div, mem_access, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, ex_mem_bubble, mem_wb_bubble, mdu_busy, mdu_done,
           stall_count
  );

  modport slave (
    input  id_ex_memread, id_ex_rt_addr, if_id_rs_addr, if_id_rt_addr,
           branch_taken, mdu_start, mdu_is_div, mem_access, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_write, ex_mem_bubble, mem_wb_bubble, mdu_busy, mdu_done,
           stall_count
  );
endinterface

// File: rtl/pipeline_hazard_controller_mdu_counter.sv
// Multiply/divide latency down-counter with a registered one-cycle done pulse.
// Counts down every cycle while nonzero; done follows the 1->0 step by one register.
module mdu_latency_counter
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int W = MDU_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt,
  output logic         o_done
);

  logic [W-1:0] r_cnt;
  logic         r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (i_load)
        r_cnt <= i_load_val;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - W'(1);
      r_done <= (r_cnt == W'(1));
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = r_done;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller: load-use, branch flush, multi-cycle MDU and memory-wait stalls.
// Controls are combinational from live inputs plus state; memory wait has top priority.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_controller_if.slave bus
);

  localparam logic [MDU_CNT_W-1:0] L_MULT = mdu_load_val(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] L_DIV  = mdu_load_val(DIV_CYCLES);

  state_t                 r_state;
  state_t                 w_next;
  state_t                 w_state;
  logic [15:0]            r_stall;
  logic [MDU_CNT_W-1:0]   w_cnt_q;
  logic [MDU_CNT_W-1:0]   w_cnt;
  logic                   w_done_q;
  logic                   w_done;
  logic                   w_memwait;
  logic                   w_loaduse;
  logic                   w_mdu_accept;
  logic                   w_mdu_busy;
  logic                   w_pc_write;
  logic                   w_if_id_write;
  logic                   w_if_id_flush;
  logic                   w_id_ex_write;
  logic                   w_id_ex_bubble;
  logic                   w_ex_mem_write;
  logic                   w_ex_mem_bubble;
  logic                   w_mem_wb_bubble;

  // While reset is held the outputs behave as if already in RUN with an idle counter.
  assign w_state = rst ? RUN : r_state;
  assign w_cnt   = rst ? '0 : w_cnt_q;
  assign w_done  = rst ? 1'b0 : w_done_q;

  assign w_memwait = bus.mem_access & ~bus.dmem_ready;
  assign w_loaduse = bus.id_ex_memread & (bus.id_ex_rt_addr != 5'd0) &
                     ((bus.id_ex_rt_addr == bus.if_id_rs_addr) |
                      (bus.id_ex_rt_addr == bus.if_id_rt_addr));
  assign w_mdu_accept = (w_state == RUN) & bus.mdu_start & ~w_memwait & ~w_done;
  assign w_mdu_busy   = w_mdu_accept | (w_cnt != '0);

  mdu_latency_counter #(.W(MDU_CNT_W)) u_mdu_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_mdu_accept),
    .i_load_val (bus.mdu_is_div ? L_DIV : L_MULT),
    .o_cnt      (w_cnt_q),
    .o_done     (w_done_q)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= RUN;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN: begin
        if (w_memwait)
          w_next = MEM_WAIT;
        else if (w_mdu_accept)
          w_next = MDU_BUSY;
      end
      MDU_BUSY: begin
        if (w_memwait)
          w_next = MEM_WAIT;
        else if (w_cnt_q == MDU_CNT_W'(1))
          w_next = RUN;
      end
      MEM_WAIT: begin
        // The counter keeps running here, so resume into whatever it will hold next.
        if (bus.dmem_ready)
          w_next = (w_cnt_q > MDU_CNT_W'(1)) ? MDU_BUSY : RUN;
      end
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_write   = 1'b1;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_write  = 1'b1;
    w_ex_mem_bubble = 1'b0;
    w_mem_wb_bubble = 1'b0;
    if (w_memwait) begin
      w_pc_write      = 1'b0;
      w_if_id_write   = 1'b0;
      w_id_ex_write   = 1'b0;
      w_ex_mem_write  = 1'b0;
      w_mem_wb_bubble = 1'b1;
    end else if (w_mdu_busy) begin
      w_pc_write      = 1'b0;
      w_if_id_write   = 1'b0;
      w_id_ex_write   = 1'b0;
      w_ex_mem_bubble = 1'b1;
    end else if (w_loaduse) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      w_if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall <= 16'd0;
    else if (!w_pc_write && (r_stall != 16'hFFFF))
      r_stall <= r_stall + 16'd1;
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.if_id_write   = w_if_id_write;
  assign bus.if_id_flush   = w_if_id_flush;
  assign bus.id_ex_write   = w_id_ex_write;
  assign bus.id_ex_bubble  = w_id_ex_bubble;
  assign bus.ex_mem_write  = w_ex_mem_write;
  assign bus.ex_mem_bubble = w_ex_mem_bubble;
  assign bus.mem_wb_bubble = w_mem_wb_bubble;
  assign bus.mdu_busy      = w_mdu_busy;
  assign bus.mdu_done      = w_done;
  assign bus.stall_count   = r_stall;

endmodule
